// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM stage controller: FSM encoding and word-alignment helpers.
package mem_stage_ctrl_pkg;

    typedef enum logic {
        MEMST_IDLE = 1'b0,
        MEMST_WAIT = 1'b1
    } mem_state_e;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_mem_wb_register.sv
// MEM/WB pipeline register; a bubble clears control bits and data so WB sees a no-op.
module mem_wb_register #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bubble,
    input  logic [DATA_W-1:0]     read_data,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [REG_ADDR_W-1:0] write_reg_addr,
    input  logic                  mem_to_reg,
    input  logic                  reg_write,
    output logic [DATA_W-1:0]     read_data_q,
    output logic [DATA_W-1:0]     alu_result_q,
    output logic [REG_ADDR_W-1:0] write_reg_addr_q,
    output logic                  mem_to_reg_q,
    output logic                  reg_write_q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data_q      <= '0;
            alu_result_q     <= '0;
            write_reg_addr_q <= '0;
            mem_to_reg_q     <= 1'b0;
            reg_write_q      <= 1'b0;
        end else if (bubble) begin
            read_data_q      <= '0;
            alu_result_q     <= '0;
            write_reg_addr_q <= '0;
            mem_to_reg_q     <= 1'b0;
            reg_write_q      <= 1'b0;
        end else begin
            read_data_q      <= read_data;
            alu_result_q     <= alu_result;
            write_reg_addr_q <= write_reg_addr;
            mem_to_reg_q     <= mem_to_reg;
            reg_write_q      <= reg_write;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: data-memory req/ack handshake with wait states, upstream stall,
// misalignment and timeout detection, feeding the MEM/WB register.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     alu_result_mem,
    input  logic [DATA_W-1:0]     write_data_mem,
    input  logic [REG_ADDR_W-1:0] write_reg_addr_mem,
    input  logic                  ctrl_MemToReg_mem,
    input  logic                  ctrl_RegWrite_mem,
    input  logic                  ctrl_MemRead_mem,
    input  logic                  ctrl_MemWrite_mem,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  stall_mem,
    output logic [DATA_W-1:0]     read_data_wb,
    output logic [DATA_W-1:0]     alu_result_wb,
    output logic [REG_ADDR_W-1:0] write_reg_addr_wb,
    output logic                  ctrl_MemToReg_wb,
    output logic                  ctrl_RegWrite_wb,
    output logic                  err_misaligned,
    output logic                  err_timeout,
    output mem_state_e            fsm_state
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    mem_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             mem_op, aligned, timeout_hit, acked;
    logic             bubble, set_misaligned, set_timeout;
    logic [DATA_W-1:0] load_data;

    assign mem_op      = ctrl_MemRead_mem | ctrl_MemWrite_mem;
    assign aligned     = is_aligned(alu_result_mem[1:0]);
    assign timeout_hit = (state == MEMST_WAIT) && (cnt == CNT_MAX);

    // Handshake: dmem_req stays high (address/data stable) until the cycle dmem_ack is
    // seen with it, or the wait budget runs out; ack without req is ignored.
    // Gating with rst drops the request the instant reset asserts, even mid-wait.
    assign dmem_req   = mem_op & aligned & rst;
    assign dmem_we    = dmem_req & ctrl_MemWrite_mem;
    assign dmem_addr  = alu_result_mem;
    assign dmem_wdata = write_data_mem;
    assign acked      = dmem_req & dmem_ack;
    assign stall_mem  = dmem_req & ~dmem_ack & ~timeout_hit;
    assign fsm_state  = state;

    // Both MemRead and MemWrite set counts as a store, so no load data is returned.
    assign load_data = (acked && !ctrl_MemWrite_mem) ? dmem_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= MEMST_IDLE;
            cnt            <= '0;
            err_misaligned <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            err_misaligned <= set_misaligned;
            if (set_timeout) begin
                err_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        bubble         = 1'b0;
        set_misaligned = 1'b0;
        set_timeout    = 1'b0;
        case (state)
            MEMST_IDLE: begin
                if (mem_op && !aligned) begin
                    bubble         = 1'b1;
                    set_misaligned = 1'b1;
                end else if (dmem_req && !dmem_ack) begin
                    state_next = MEMST_WAIT;
                    cnt_next   = CNT_W'(1);
                    bubble     = 1'b1;
                end
            end
            MEMST_WAIT: begin
                if (acked) begin
                    state_next = MEMST_IDLE;
                    cnt_next   = '0;
                end else if (!dmem_req || timeout_hit) begin
                    // Abandon the access; the instruction is discarded as a bubble.
                    state_next  = MEMST_IDLE;
                    cnt_next    = '0;
                    bubble      = 1'b1;
                    set_timeout = timeout_hit;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                    bubble   = 1'b1;
                end
            end
            default: begin
                state_next = MEMST_IDLE;
                cnt_next   = '0;
                bubble     = 1'b1;
            end
        endcase
    end

    mem_wb_register #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_mem_wb (
        .clk              (clk),
        .rst              (rst),
        .bubble           (bubble),
        .read_data        (load_data),
        .alu_result       (alu_result_mem),
        .write_reg_addr   (write_reg_addr_mem),
        .mem_to_reg       (ctrl_MemToReg_mem),
        .reg_write        (ctrl_RegWrite_mem),
        .read_data_q      (read_data_wb),
        .alu_result_q     (alu_result_wb),
        .write_reg_addr_q (write_reg_addr_wb),
        .mem_to_reg_q     (ctrl_MemToReg_wb),
        .reg_write_q      (ctrl_RegWrite_wb)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: constant vector table, directed multi-cycle sequences and
// randomized traffic against a cycle-level reference model.
module tb_mem_stage_ctrl;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MAX_WAIT   = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [DATA_W-1:0]     alu_result_mem, write_data_mem, dmem_addr, dmem_wdata, dmem_rdata;
    logic [DATA_W-1:0]     read_data_wb, alu_result_wb;
    logic [REG_ADDR_W-1:0] write_reg_addr_mem, write_reg_addr_wb;
    logic                  ctrl_MemToReg_mem, ctrl_RegWrite_mem, ctrl_MemRead_mem, ctrl_MemWrite_mem;
    logic                  dmem_req, dmem_we, dmem_ack, stall_mem;
    logic                  ctrl_MemToReg_wb, ctrl_RegWrite_wb, err_misaligned, err_timeout;
    logic                  fsm_state;

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .alu_result_mem     (alu_result_mem),
        .write_data_mem     (write_data_mem),
        .write_reg_addr_mem (write_reg_addr_mem),
        .ctrl_MemToReg_mem  (ctrl_MemToReg_mem),
        .ctrl_RegWrite_mem  (ctrl_RegWrite_mem),
        .ctrl_MemRead_mem   (ctrl_MemRead_mem),
        .ctrl_MemWrite_mem  (ctrl_MemWrite_mem),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_rdata         (dmem_rdata),
        .dmem_ack           (dmem_ack),
        .stall_mem          (stall_mem),
        .read_data_wb       (read_data_wb),
        .alu_result_wb      (alu_result_wb),
        .write_reg_addr_wb  (write_reg_addr_wb),
        .ctrl_MemToReg_wb   (ctrl_MemToReg_wb),
        .ctrl_RegWrite_wb   (ctrl_RegWrite_wb),
        .err_misaligned     (err_misaligned),
        .err_timeout        (err_timeout),
        .fsm_state          (fsm_state)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: cycles the current access has already waited, plus predicted WB state.
    int                    waited;
    logic [DATA_W-1:0]     e_rd, e_alu;
    logic [REG_ADDR_W-1:0] e_wra;
    logic                  e_m2r, e_rw, e_mis, e_tout;
    int                    stall_seen, req_seen, rw_seen;
    logic                  rw_hist[$];
    logic [DATA_W-1:0]     alu_hist[$];

    typedef struct {
        logic                  rd, wr, ack, rw, m2r;
        logic [DATA_W-1:0]     addr, wdata, rdata;
        logic [REG_ADDR_W-1:0] wra;
        logic                  x_req, x_we, x_rw, x_m2r, x_mis;
        logic [DATA_W-1:0]     x_rd, x_alu;
        logic [REG_ADDR_W-1:0] x_wra;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        waited = 0;
        e_rd = '0; e_alu = '0; e_wra = '0;
        e_m2r = 1'b0; e_rw = 1'b0; e_mis = 1'b0; e_tout = 1'b0;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [DATA_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [REG_ADDR_W-1:0] wra,
                          input logic m2r, input logic rw);
        ctrl_MemRead_mem   = rd;
        ctrl_MemWrite_mem  = wr;
        alu_result_mem     = addr;
        write_data_mem     = wdata;
        write_reg_addr_mem = wra;
        ctrl_MemToReg_mem  = m2r;
        ctrl_RegWrite_mem  = rw;
    endtask

    task automatic set_ack(input logic ack, input logic [DATA_W-1:0] rdata);
        dmem_ack   = ack;
        dmem_rdata = rdata;
    endtask

    // Called at a negedge with inputs applied; checks combinational outputs, clocks once,
    // checks the registered outputs, and returns at the next negedge.
    task automatic cycle();
        logic mem_op, aligned, req, acked, tmo;
        mem_op  = ctrl_MemRead_mem | ctrl_MemWrite_mem;
        aligned = (alu_result_mem % 4) == 0;
        req     = mem_op && aligned;
        acked   = req && dmem_ack;
        tmo     = req && !dmem_ack && (waited == MAX_WAIT);
        #1;
        check("dmem_req", dmem_req, req);
        check("dmem_we", dmem_we, req && ctrl_MemWrite_mem);
        check("stall_mem", stall_mem, req && !dmem_ack && !tmo);
        check("dmem_addr", dmem_addr, alu_result_mem);
        check("dmem_wdata", dmem_wdata, write_data_mem);
        stall_seen += int'(stall_mem);
        req_seen   += int'(dmem_req);
        if (!mem_op || acked) begin
            e_alu = alu_result_mem;
            e_wra = write_reg_addr_mem;
            e_m2r = ctrl_MemToReg_mem;
            e_rw  = ctrl_RegWrite_mem;
            e_rd  = (acked && !ctrl_MemWrite_mem) ? dmem_rdata : '0;
        end else begin
            e_alu = '0; e_wra = '0; e_m2r = 1'b0; e_rw = 1'b0; e_rd = '0;
        end
        e_mis = mem_op && !aligned && (waited == 0);
        if (tmo) e_tout = 1'b1;
        waited = (req && !dmem_ack && !tmo) ? waited + 1 : 0;
        @(posedge clk);
        #1;
        check("read_data_wb", read_data_wb, e_rd);
        check("alu_result_wb", alu_result_wb, e_alu);
        check("write_reg_addr_wb", write_reg_addr_wb, e_wra);
        check("MemToReg_wb", ctrl_MemToReg_wb, e_m2r);
        check("RegWrite_wb", ctrl_RegWrite_wb, e_rw);
        check("err_misaligned", err_misaligned, e_mis);
        check("err_timeout", err_timeout, e_tout);
        check("fsm_state", fsm_state, (waited > 0) ? 1'b1 : 1'b0);
        rw_seen += int'(ctrl_RegWrite_wb);
        rw_hist.push_back(ctrl_RegWrite_wb);
        alu_hist.push_back(alu_result_wb);
        @(negedge clk);
    endtask

    task automatic clear_tallies();
        stall_seen = 0; req_seen = 0; rw_seen = 0;
        rw_hist.delete();
        alu_hist.delete();
    endtask

    initial begin
        //            rd  wr  ack rw  m2r addr         wdata  rdata         wra  req we rw m2r mis rd            alu      wra
        vecs[0] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h1234,    32'h0, 32'h0,        5'd3, 1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h1234,5'd3};
        vecs[1] = '{1'b1,1'b0,1'b1,1'b1,1'b1,32'h10,      32'h0, 32'hDEADBEEF, 5'd5, 1'b1,1'b0,1'b1,1'b1,1'b0,32'hDEADBEEF, 32'h10,  5'd5};
        vecs[2] = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h40,      32'h55,32'hFFFF0000, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h40,  5'd0};
        vecs[3] = '{1'b1,1'b0,1'b0,1'b1,1'b1,32'h22,      32'h0, 32'h0,        5'd6, 1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,        32'h0,   5'd0};
        vecs[4] = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h13,      32'h9, 32'h0,        5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,        32'h0,   5'd0};
        vecs[5] = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h8,       32'h3, 32'hCAFE,     5'd4, 1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h8,   5'd4};
        vecs[6] = '{1'b0,1'b0,1'b1,1'b1,1'b0,32'h21,      32'h0, 32'h777,      5'd7, 1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h21,  5'd7};

        // Reset state, with an aligned load presented so the request gating is exercised.
        rst = 1'b0;
        set_op(1'b1, 1'b0, 32'h30, 32'h0, 5'd1, 1'b1, 1'b1);
        set_ack(1'b0, 32'h0);
        model_reset();
        clear_tallies();
        repeat (2) @(posedge clk);
        #1;
        check("reset dmem_req", dmem_req, 1'b0);
        check("reset stall_mem", stall_mem, 1'b0);
        check("reset fsm_state", fsm_state, 1'b0);
        check("reset alu_result_wb", alu_result_wb, 32'h0);
        check("reset RegWrite_wb", ctrl_RegWrite_wb, 1'b0);
        check("reset err_timeout", err_timeout, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Single-cycle vectors from IDLE against constant expectations.
        for (int i = 0; i < 7; i++) begin
            set_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wra, vecs[i].m2r, vecs[i].rw);
            set_ack(vecs[i].ack, vecs[i].rdata);
            cycle();
            check($sformatf("vec%0d req", i), dmem_req, vecs[i].x_req);
            check($sformatf("vec%0d we", i), dmem_we, vecs[i].x_we);
            check($sformatf("vec%0d stall", i), stall_mem, 1'b0);
            check($sformatf("vec%0d rd_wb", i), read_data_wb, vecs[i].x_rd);
            check($sformatf("vec%0d alu_wb", i), alu_result_wb, vecs[i].x_alu);
            check($sformatf("vec%0d wra_wb", i), write_reg_addr_wb, vecs[i].x_wra);
            check($sformatf("vec%0d rw_wb", i), ctrl_RegWrite_wb, vecs[i].x_rw);
            check($sformatf("vec%0d m2r_wb", i), ctrl_MemToReg_wb, vecs[i].x_m2r);
            check($sformatf("vec%0d mis", i), err_misaligned, vecs[i].x_mis);
        end

        // Store with three wait states, acked on the fourth request cycle.
        clear_tallies();
        set_op(1'b0, 1'b1, 32'h20, 32'h55, 5'd0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            set_ack(c == 3, 32'h0);
            cycle();
        end
        check("store3 stall cycles", stall_seen, 3);
        check("store3 req cycles", req_seen, 4);
        check("store3 regwrite", rw_seen, 0);
        check("store3 bubble alu", alu_hist[2], 32'h0);
        check("store3 done alu", alu_hist[3], 32'h20);

        // Load that is never acked: four stall cycles, then timeout releases the pipe.
        clear_tallies();
        set_op(1'b1, 1'b0, 32'h44, 32'h0, 5'd9, 1'b1, 1'b1);
        set_ack(1'b0, 32'h0);
        for (int c = 0; c < MAX_WAIT + 1; c++) cycle();
        check("timeout stall cycles", stall_seen, MAX_WAIT);
        check("timeout flag", err_timeout, 1'b1);
        check("timeout regwrite", rw_seen, 0);
        set_op(1'b0, 1'b0, 32'h50, 32'h0, 5'd10, 1'b0, 1'b1);
        cycle();
        check("post-timeout alu", alu_result_wb, 32'h50);
        check("post-timeout rw", ctrl_RegWrite_wb, 1'b1);
        check("timeout sticky", err_timeout, 1'b1);

        // Reset asserted asynchronously during the second wait cycle.
        set_op(1'b1, 1'b0, 32'h60, 32'h0, 5'd11, 1'b1, 1'b1);
        set_ack(1'b0, 32'h0);
        cycle();
        cycle();
        #2;
        rst = 1'b0;
        #1;
        check("midwait dmem_req", dmem_req, 1'b0);
        check("midwait stall", stall_mem, 1'b0);
        check("midwait state", fsm_state, 1'b0);
        check("midwait rw_wb", ctrl_RegWrite_wb, 1'b0);
        check("midwait rd_wb", read_data_wb, 32'h0);
        check("midwait err_timeout", err_timeout, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        set_op(1'b0, 1'b0, 32'h70, 32'h0, 5'd12, 1'b0, 1'b1);
        cycle();
        check("after reset alu", alu_result_wb, 32'h70);
        check("after reset rw", ctrl_RegWrite_wb, 1'b1);

        // ALU, one-wait load, ALU: WB sees ALU, bubble, load, ALU.
        clear_tallies();
        set_op(1'b0, 1'b0, 32'h100, 32'h0, 5'd1, 1'b0, 1'b1);
        set_ack(1'b0, 32'h0);
        cycle();
        set_op(1'b1, 1'b0, 32'h104, 32'h0, 5'd2, 1'b1, 1'b1);
        cycle();
        set_ack(1'b1, 32'hA5A5A5A5);
        cycle();
        check("b2b load data", read_data_wb, 32'hA5A5A5A5);
        set_op(1'b0, 1'b0, 32'h108, 32'h0, 5'd3, 1'b0, 1'b1);
        set_ack(1'b0, 32'h0);
        cycle();
        check("b2b rw count", rw_seen, 3);
        check("b2b rw seq", {rw_hist[0], rw_hist[1], rw_hist[2], rw_hist[3]}, 4'b1011);
        check("b2b alu0", alu_hist[0], 32'h100);
        check("b2b alu1", alu_hist[1], 32'h0);
        check("b2b alu2", alu_hist[2], 32'h104);
        check("b2b alu3", alu_hist[3], 32'h108);

        // Random traffic; instruction held while the model says an access is outstanding.
        for (int i = 0; i < 600; i++) begin
            if (waited == 0) begin
                int op;
                logic [DATA_W-1:0] a;
                op = $urandom_range(0, 3);
                a = $urandom;
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                set_op(op == 1 || op == 3, op >= 2, a, $urandom, REG_ADDR_W'($urandom),
                       1'($urandom), 1'($urandom));
            end
            set_ack($urandom_range(0, 3) == 0, $urandom);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                model_reset();
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
